ram_march_tester: RTL and testbench

Hardware initiator for the 64 x 8 single-port RAM: on a start pulse it drives the RAM's data/addr/write_enable port through a four-phase march (write pattern, read-verify, write inverse, read-verify). It checks every read-back word and reports pass/fail, an error count, and the first failing location. It sits beside the single_port_ram instance and replaces bench-driven stimulus with an on-chip self-test.

---
 rtl/ram_march_tester.sv | 216 +++++++++++++++++++++
 tb/tb_ram_march_tester.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_march_tester.sv
// ram_march_tester: on-chip march self-test initiator for a 64 x 8 single-port RAM.
// Runs write-PATTERN / read-verify / write-~PATTERN / read-verify and reports
// pass/fail, mismatch count and the first failing location.
module ram_march_tester #(
    parameter logic [7:0] PATTERN = 8'h55,
    parameter int         RD_LAT  = 1      // RAM read latency: 0, 1 or 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] ram_data,
    output logic [5:0] ram_addr,
    output logic       ram_write_enable,
    input  logic [7:0] ram_read,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [7:0] err_count,
    output logic [5:0] first_fail_addr,
    output logic [7:0] first_fail_data
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W0   = 3'd1,
        ST_R0   = 3'd2,
        ST_W1   = 3'd3,
        ST_R1   = 3'd4
    } state_t;

    // Last cycle index of a write phase and of a read phase (reads include drain).
    localparam logic [6:0] W_LAST = 7'd63;
    localparam logic [6:0] R_LAST = 7'(63 + RD_LAT);

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [5:0] ram_addr_q, ram_addr_d;
    logic [7:0] ram_data_q, ram_data_d;
    logic       ram_we_q, ram_we_d;
    logic       rd_vld_q, rd_vld_d;     // current cycle presents a read address
    logic [7:0] exp_q, exp_d;           // expected word for the read presented now
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       fail_q, fail_d;
    logic [7:0] err_q, err_d;
    logic [5:0] ffa_q, ffa_d;
    logic [7:0] ffd_q, ffd_d;

    // Compare tap: the {valid, addr, expected} tuple whose data is on ram_read now.
    logic       tap_vld;
    logic [5:0] tap_addr;
    logic [7:0] tap_exp;

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign tap_vld  = rd_vld_q;
            assign tap_addr = ram_addr_q;
            assign tap_exp  = exp_q;
        end else begin : g_latn
            logic       pv_q [RD_LAT];
            logic [5:0] pa_q [RD_LAT];
            logic [7:0] pe_q [RD_LAT];

            // Shift the read descriptor alongside the RAM's read latency.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < RD_LAT; i++) begin
                        pv_q[i] <= 1'b0;
                        pa_q[i] <= '0;
                        pe_q[i] <= '0;
                    end
                end else begin
                    pv_q[0] <= rd_vld_q;
                    pa_q[0] <= ram_addr_q;
                    pe_q[0] <= exp_q;
                    for (int i = 1; i < RD_LAT; i++) begin
                        pv_q[i] <= pv_q[i-1];
                        pa_q[i] <= pa_q[i-1];
                        pe_q[i] <= pe_q[i-1];
                    end
                end
            end

            assign tap_vld  = pv_q[RD_LAT-1];
            assign tap_addr = pa_q[RD_LAT-1];
            assign tap_exp  = pe_q[RD_LAT-1];
        end
    endgenerate

    // Next-state logic: phase sequencing, RAM port drive and result accumulation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;
        rd_vld_d   = 1'b0;
        exp_d      = exp_q;
        busy_d     = busy_q;
        done_d     = done_q;
        fail_d     = fail_q;
        err_d      = err_q;
        ffa_d      = ffa_q;
        ffd_d      = ffd_q;

        // At most 128 compares per run, so the 8-bit count never wraps.
        if (tap_vld && (ram_read != tap_exp)) begin
            err_d  = err_q + 8'd1;
            fail_d = 1'b1;
            if (err_q == 8'd0) begin
                ffa_d = tap_addr;
                ffd_d = ram_read;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_W0;
                    cnt_d      = '0;
                    ram_addr_d = '0;
                    ram_data_d = PATTERN;
                    ram_we_d   = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                    err_d      = '0;
                    ffa_d      = '0;
                    ffd_d      = '0;
                end
            end
            ST_W0, ST_W1: begin
                if (cnt_q == W_LAST) begin
                    state_d    = (state_q == ST_W0) ? ST_R0 : ST_R1;
                    cnt_d      = '0;
                    ram_addr_d = '0;
                    rd_vld_d   = 1'b1;
                    exp_d      = (state_q == ST_W0) ? PATTERN : ~PATTERN;
                end else begin
                    cnt_d      = cnt_q + 7'd1;
                    ram_addr_d = cnt_q[5:0] + 6'd1;
                    ram_we_d   = 1'b1;
                end
            end
            ST_R0, ST_R1: begin
                if (cnt_q == R_LAST) begin
                    cnt_d = '0;
                    if (state_q == ST_R0) begin
                        state_d    = ST_W1;
                        ram_addr_d = '0;
                        ram_data_d = ~PATTERN;
                        ram_we_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 7'd1;
                    // Past address 63 only drain cycles remain: hold the address.
                    if (cnt_q < W_LAST) begin
                        ram_addr_d = cnt_q[5:0] + 6'd1;
                        rd_vld_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            exp_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            err_q      <= '0;
            ffa_q      <= '0;
            ffd_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            rd_vld_q   <= rd_vld_d;
            exp_q      <= exp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            ffa_q      <= ffa_d;
            ffd_q      <= ffd_d;
        end
    end

    assign ram_data         = ram_data_q;
    assign ram_addr         = ram_addr_q;
    assign ram_write_enable = ram_we_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign fail             = fail_q;
    assign err_count        = err_q;
    assign first_fail_addr  = ffa_q;
    assign first_fail_data  = ffd_q;

endmodule

// File: tb/tb_ram_march_tester.sv
// tb_ram_march_tester: drives ram_march_tester against a behavioural RAM with
// configurable faults and compares every run to a march reference model.
module tb_ram_march_tester;

    parameter int LAT = 1;
    localparam logic [7:0] PAT      = 8'h55;
    localparam int         BUSY_EXP = 256 + 2 * LAT;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] ram_data;
    logic [5:0] ram_addr;
    logic       ram_write_enable;
    logic [7:0] ram_read;
    logic       busy;
    logic       done;
    logic       fail;
    logic [7:0] err_count;
    logic [5:0] first_fail_addr;
    logic [7:0] first_fail_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Fault slots: kind 0 = one bit stuck at f_val[0], kind 1 = whole word reads f_val.
    logic       f_en   [2];
    logic [5:0] f_addr [2];
    logic       f_kind [2];
    logic [2:0] f_bit  [2];
    logic [7:0] f_val  [2];

    ram_march_tester #(.PATTERN(PAT), .RD_LAT(LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .ram_data         (ram_data),
        .ram_addr         (ram_addr),
        .ram_write_enable (ram_write_enable),
        .ram_read         (ram_read),
        .busy             (busy),
        .done             (done),
        .fail             (fail),
        .err_count        (err_count),
        .first_fail_addr  (first_fail_addr),
        .first_fail_data  (first_fail_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fault_rd(input logic [5:0] a, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < 2; i++) begin
            if (f_en[i] && f_addr[i] == a) begin
                if (f_kind[i]) r = f_val[i];
                else           r[f_bit[i]] = f_val[i][0];
            end
        end
        return r;
    endfunction

    // Behavioural RAM with LAT-cycle read latency and read-side fault injection.
    logic [7:0] mem [64];
    logic [7:0] rd_raw, rd_p1, rd_p2;
    always @(posedge clk) if (ram_write_enable) mem[ram_addr] <= ram_data;
    always_comb rd_raw = fault_rd(ram_addr, mem[ram_addr]);
    always @(posedge clk) begin
        rd_p1 <= rd_raw;
        rd_p2 <= rd_p1;
    end
    assign ram_read = (LAT == 0) ? rd_raw : (LAT == 1) ? rd_p1 : rd_p2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h required %0h", tag, got, exp);
        end
    endtask

    // Reference: march over a plain array, reads pass through the fault function.
    task automatic model_run(output int ec, output logic [5:0] fa, output logic [7:0] fd);
        logic [7:0] bg [64];
        logic [7:0] w, rdv;
        ec = 0; fa = '0; fd = '0;
        for (int ph = 0; ph < 2; ph++) begin
            w = (ph == 0) ? PAT : ~PAT;
            for (int a = 0; a < 64; a++) bg[a] = w;
            for (int a = 0; a < 64; a++) begin
                rdv = fault_rd(6'(a), bg[a]);
                if (rdv != w) begin
                    if (ec == 0) begin
                        fa = 6'(a);
                        fd = rdv;
                    end
                    ec++;
                end
            end
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 2; i++) begin
            f_en[i] = 1'b0; f_addr[i] = '0; f_kind[i] = 1'b0; f_bit[i] = '0; f_val[i] = '0;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_busy"}, 32'(busy), 0);
        check_eq({pfx, "_done"}, 32'(done), 0);
        check_eq({pfx, "_fail"}, 32'(fail), 0);
        check_eq({pfx, "_err"},  32'(err_count), 0);
        check_eq({pfx, "_ffa"},  32'(first_fail_addr), 0);
        check_eq({pfx, "_ffd"},  32'(first_fail_data), 0);
        check_eq({pfx, "_addr"}, 32'(ram_addr), 0);
        check_eq({pfx, "_data"}, 32'(ram_data), 0);
        check_eq({pfx, "_we"},   32'(ram_write_enable), 0);
    endtask

    // Pulse start, verify E0 state, count busy cycles (extra start pulses at
    // busy cycles p1/p2), then compare results with the model.
    task automatic run_march(input string name, input int p1, input int p2);
        int ec, bcyc, nwr;
        logic [5:0] fa;
        logic [7:0] fd;
        model_run(ec, fa, fd);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({name, "_e0_busy"}, 32'(busy), 1);
        check_eq({name, "_e0_addr"}, 32'(ram_addr), 0);
        check_eq({name, "_e0_we"},   32'(ram_write_enable), 1);
        check_eq({name, "_e0_data"}, 32'(ram_data), 32'(PAT));
        check_eq({name, "_e0_clr"},  {done, fail, err_count, first_fail_addr, first_fail_data}, 0);
        bcyc = 0;
        nwr  = 0;
        while (busy && bcyc < 2000) begin
            bcyc++;
            if (ram_write_enable) nwr++;
            start = (bcyc == p1 || bcyc == p2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_eq({name, "_busy_len"}, 32'(bcyc), 32'(BUSY_EXP));
        check_eq({name, "_writes"},   32'(nwr), 128);
        check_eq({name, "_done"},     32'(done), 1);
        check_eq({name, "_fail"},     32'(fail), 32'(ec != 0));
        check_eq({name, "_err"},      32'(err_count), 32'(ec));
        check_eq({name, "_ffa"},      32'(first_fail_addr), 32'(fa));
        check_eq({name, "_ffd"},      32'(first_fail_data), 32'(fd));
        $display("run %s: busy=%0d err=%0d first=%0h/%0h (model err=%0d first=%0h/%0h)",
                 name, bcyc, err_count, first_fail_addr, first_fail_data, ec, fa, fd);
    endtask

    initial begin
        int bcyc, bad;
        for (int a = 0; a < 64; a++) mem[a] = 8'h00;
        clear_faults();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean RAM: full pass, RAM left holding ~PATTERN, done held afterwards.
        run_march("clean", 0, 0);
        bad = 0;
        for (int a = 0; a < 64; a++) if (mem[a] != ~PAT) bad++;
        check_eq("clean_mem_words_not_aa", 32'(bad), 0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("clean_done_held", 32'(done), 1);

        // Bit 0 of address 0x05 stuck at 1: only R1 sees it.
        clear_faults();
        f_en[0] = 1'b1; f_addr[0] = 6'h05; f_kind[0] = 1'b0; f_bit[0] = 3'd0; f_val[0] = 8'h01;
        run_march("stuck5", 0, 0);
        check_eq("stuck5_err_const", 32'(err_count), 1);
        check_eq("stuck5_ffd_const", 32'(first_fail_data), 32'h00AB);

        // Address 0x3F always reads 0: last address compared in both read phases.
        clear_faults();
        f_en[0] = 1'b1; f_addr[0] = 6'h3F; f_kind[0] = 1'b1; f_val[0] = 8'h00;
        run_march("zero3f", 0, 0);
        check_eq("zero3f_err_const", 32'(err_count), 2);
        check_eq("zero3f_ffa_const", 32'(first_fail_addr), 32'h3F);

        // start pulses while busy are ignored.
        clear_faults();
        f_en[0] = 1'b1; f_addr[0] = 6'($urandom_range(0, 63)); f_kind[0] = 1'b1;
        f_val[0] = 8'($urandom);
        run_march("restart_ignored", 10, 200);

        // rst at busy cycle 100 aborts the run; a following run is complete and clean.
        clear_faults();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bcyc = 1;
        while (busy && bcyc < 100) begin
            bcyc++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midrst");
        repeat (3) @(posedge clk);
        #1;
        check_eq("midrst_idle_busy", 32'(busy), 0);
        run_march("after_rst", 0, 0);

        // Randomised fault configurations, run back to back.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 2; i++) begin
                f_en[i]   = 1'($urandom_range(0, 1));
                f_addr[i] = 6'($urandom_range(0, 63));
                f_kind[i] = 1'($urandom_range(0, 1));
                f_bit[i]  = 3'($urandom_range(0, 7));
                f_val[i]  = 8'($urandom);
            end
            run_march($sformatf("rand%0d", r), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
